// File: rtl/ras_ss_pkg.sv
// Purpose: shared types and helpers for the return-address shadow stack checker.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state enum, overflow-policy constants, modulo-DEPTH pointer helpers.
package ras_ss_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } ss_state_e;

  localparam int OVF_SAT  = 0;  // full: drop the call and count it
  localparam int OVF_CIRC = 1;  // full: overwrite the oldest entry

  // Modulo increment by explicit compare so non-power-of-2 depths wrap correctly.
  function automatic int unsigned ss_mod_inc(input int unsigned v, input int unsigned depth);
    return (v >= depth - 32'd1) ? 32'd0 : v + 32'd1;
  endfunction

  function automatic int unsigned ss_mod_dec(input int unsigned v, input int unsigned depth);
    return (v == 32'd0) ? depth - 32'd1 : v - 32'd1;
  endfunction

endpackage

// File: rtl/ras_ss_if.sv
// Purpose: commit-stage call/return bus and status outputs of the shadow stack checker.
// Latency: n/a (wiring only).
// Backpressure: none; commit events are never stalled, HALT simply ignores them.
//
// master: the commit stage / software side. slave: the checker.
interface ras_ss_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 5
);
  logic              i_flush;
  logic              i_call;
  logic [DATA_W-1:0] i_call_addr;
  logic              i_ret;
  logic [DATA_W-1:0] i_ret_addr;
  logic              i_viol_ack;
  logic              i_clr_sticky;
  logic [DATA_W-1:0] o_top;
  logic [CNT_W-1:0]  o_count;
  logic              o_empty;
  logic              o_full;
  logic              o_halted;
  logic              o_viol;
  logic [DATA_W-1:0] o_viol_exp;
  logic [DATA_W-1:0] o_viol_act;
  logic              o_ovf;
  logic              o_unf;
  logic              o_desync;

  modport master (
    output i_flush, i_call, i_call_addr, i_ret, i_ret_addr, i_viol_ack, i_clr_sticky,
    input  o_top, o_count, o_empty, o_full, o_halted, o_viol, o_viol_exp, o_viol_act,
           o_ovf, o_unf, o_desync
  );

  modport slave (
    input  i_flush, i_call, i_call_addr, i_ret, i_ret_addr, i_viol_ack, i_clr_sticky,
    output o_top, o_count, o_empty, o_full, o_halted, o_viol, o_viol_exp, o_viol_act,
           o_ovf, o_unf, o_desync
  );

endinterface

// File: rtl/ras_ss_ptr.sv
// Purpose: pointer, count and drop-counter update plus full/empty/desync state.
// Latency: state updates at the next edge; status and write controls are combinational.
// Backpressure: none; call/ret must already be gated by the caller's RUN state.
//
// Ports: i_flush/i_call/i_ret in; o_wr_en/o_wr_idx steer the storage write,
// o_top_idx addresses the current top, o_chk requests a compare, o_ovf_set/o_unf_set
// feed the sticky flags, o_count/o_empty/o_full/o_desync are status.
module ras_ss_ptr
  import ras_ss_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int OVF_MODE = OVF_SAT,
  parameter int CNT_W    = $clog2(DEPTH + 1),
  parameter int IDX_W    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_flush,
  input  logic             i_call,
  input  logic             i_ret,
  output logic [IDX_W-1:0] o_top_idx,
  output logic [IDX_W-1:0] o_wr_idx,
  output logic             o_wr_en,
  output logic             o_chk,
  output logic             o_ovf_set,
  output logic             o_unf_set,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_desync
);

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] DROP_MAX = CNT_W'(DEPTH - 1);

  logic [IDX_W-1:0] r_ptr;      // next write slot; the oldest entry when full
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_drops;    // calls dropped while full, still owed a return
  logic             r_desync;

  logic [IDX_W-1:0] w_ptr_inc;
  logic [IDX_W-1:0] w_ptr_dec;
  logic             w_full;
  logic             w_pop;
  logic [IDX_W-1:0] w_nptr;
  logic [CNT_W-1:0] w_ncnt;
  logic [CNT_W-1:0] w_ndrops;
  logic             w_ndesync;

  assign w_ptr_inc = IDX_W'(ss_mod_inc(32'(r_ptr), DEPTH));
  assign w_ptr_dec = IDX_W'(ss_mod_dec(32'(r_ptr), DEPTH));
  assign w_full    = (r_cnt == DEPTH_C);

  assign o_top_idx = w_ptr_dec;
  assign o_count   = r_cnt;
  assign o_empty   = (r_cnt == '0);
  assign o_full    = w_full;
  assign o_desync  = r_desync;

  always_comb begin
    w_pop     = 1'b0;
    w_nptr    = r_ptr;
    w_ncnt    = r_cnt;
    w_ndrops  = r_drops;
    w_ndesync = r_desync;
    o_wr_en   = 1'b0;
    o_wr_idx  = r_ptr;
    o_chk     = 1'b0;
    o_ovf_set = 1'b0;
    o_unf_set = 1'b0;
    if (i_flush) begin
      w_nptr    = '0;
      w_ncnt    = '0;
      w_ndrops  = '0;
      w_ndesync = 1'b0;
    end else begin
      // Return first: it always sees the pre-call top.
      if (i_ret) begin
        if (r_cnt != '0 && (r_drops == '0 || r_desync)) begin
          w_pop  = 1'b1;
          o_chk  = !r_desync;
          w_nptr = w_ptr_dec;
          w_ncnt = r_cnt - 1'b1;
        end else if (r_drops != '0) begin
          // This return belongs to a dropped call; nothing stored to compare.
          w_ndrops = r_drops - 1'b1;
        end else begin
          o_unf_set = 1'b1;
        end
      end
      if (i_call) begin
        if (w_pop) begin
          // Same-cycle call reuses the slot the return just freed.
          o_wr_en  = 1'b1;
          o_wr_idx = w_ptr_dec;
          w_nptr   = r_ptr;
          w_ncnt   = r_cnt;
        end else if (!w_full) begin
          o_wr_en  = 1'b1;
          o_wr_idx = r_ptr;
          w_nptr   = w_ptr_inc;
          w_ncnt   = r_cnt + 1'b1;
        end else if (OVF_MODE == OVF_CIRC) begin
          o_wr_en   = 1'b1;
          o_wr_idx  = r_ptr;
          w_nptr    = w_ptr_inc;
          o_ovf_set = 1'b1;
        end else begin
          o_ovf_set = 1'b1;
          if (w_ndrops == DROP_MAX) w_ndesync = 1'b1;
          else                      w_ndrops  = w_ndrops + 1'b1;
        end
      end
      // Everything owed has been returned: the stack is back in step.
      if (w_ncnt == '0 && w_ndrops == '0) w_ndesync = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_drops  <= '0;
      r_desync <= 1'b0;
    end else begin
      r_ptr    <= w_nptr;
      r_cnt    <= w_ncnt;
      r_drops  <= w_ndrops;
      r_desync <= w_ndesync;
    end
  end

endmodule

// File: rtl/ras_shadow_stack_chk.sv
// Purpose: checked return-address shadow stack; commit calls push, returns pop and compare.
// Latency: status 0 cycles after the edge; o_viol/o_halted 1 cycle after the bad return.
// Backpressure: none; in HALT calls/returns are ignored until i_viol_ack.
//
// Ports: clk, rstn (sync, active-low), bus (ras_ss_if.slave) carrying commit
// call/return, flush, ack, sticky clear, and all stack/violation status outputs.
module ras_shadow_stack_chk
  import ras_ss_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 16,
  parameter int OVF_MODE = OVF_SAT,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic    clk,
  input  logic    rstn,
  ras_ss_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);

  ss_state_e         r_state;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_viol;
  logic [DATA_W-1:0] r_viol_exp;
  logic [DATA_W-1:0] r_viol_act;
  logic              r_ovf;
  logic              r_unf;

  logic              w_run;
  logic [IDX_W-1:0]  w_top_idx;
  logic [IDX_W-1:0]  w_wr_idx;
  logic              w_wr_en;
  logic              w_chk;
  logic              w_ovf_set;
  logic              w_unf_set;
  logic              w_empty;
  logic [DATA_W-1:0] w_top_dat;
  logic              w_mis;

  assign w_run     = (r_state == RUN);
  assign w_top_dat = r_mem[w_top_idx];
  assign w_mis     = w_chk && (bus.i_ret_addr != w_top_dat);

  ras_ss_ptr #(
    .DEPTH    (DEPTH),
    .OVF_MODE (OVF_MODE),
    .CNT_W    (CNT_W),
    .IDX_W    (IDX_W)
  ) u_ptr (
    .clk       (clk),
    .rstn      (rstn),
    .i_flush   (bus.i_flush),
    .i_call    (bus.i_call & w_run),
    .i_ret     (bus.i_ret & w_run),
    .o_top_idx (w_top_idx),
    .o_wr_idx  (w_wr_idx),
    .o_wr_en   (w_wr_en),
    .o_chk     (w_chk),
    .o_ovf_set (w_ovf_set),
    .o_unf_set (w_unf_set),
    .o_count   (bus.o_count),
    .o_empty   (w_empty),
    .o_full    (bus.o_full),
    .o_desync  (bus.o_desync)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[w_wr_idx] <= bus.i_call_addr;
    end
  end

  // FSM plus its registered outputs and the sticky flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= RUN;
      r_viol     <= 1'b0;
      r_viol_exp <= '0;
      r_viol_act <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      r_viol <= 1'b0;
      case (r_state)
        RUN: begin
          if (w_mis) begin
            r_state    <= HALT;
            r_viol     <= 1'b1;
            r_viol_exp <= w_top_dat;
            r_viol_act <= bus.i_ret_addr;
          end
        end
        HALT: begin
          if (bus.i_viol_ack) r_state <= RUN;
        end
        default: r_state <= RUN;
      endcase
      // A same-cycle set wins over the clear.
      if (w_ovf_set)             r_ovf <= 1'b1;
      else if (bus.i_clr_sticky) r_ovf <= 1'b0;
      if (w_unf_set)             r_unf <= 1'b1;
      else if (bus.i_clr_sticky) r_unf <= 1'b0;
    end
  end

  assign bus.o_top      = w_empty ? '0 : w_top_dat;
  assign bus.o_empty    = w_empty;
  assign bus.o_halted   = (r_state == HALT);
  assign bus.o_viol     = r_viol;
  assign bus.o_viol_exp = r_viol_exp;
  assign bus.o_viol_act = r_viol_act;
  assign bus.o_ovf      = r_ovf;
  assign bus.o_unf      = r_unf;

endmodule

// File: tb/tb_ras_shadow_stack_chk.sv
module tb_ras_shadow_stack_chk;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush, call, ret, ack, clr;
  logic [63:0] caddr, raddr;
  int          tests = 0;
  int          failed = 0;

  typedef struct {
    int          sel;   // 0: saturating instance, 1: circular instance
    logic        viol;
    logic [63:0] e;
    logic [63:0] a;
  } sb_t;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  ras_ss_if #(.DATA_W(64), .CNT_W(3)) if_sat ();
  ras_ss_if #(.DATA_W(64), .CNT_W(3)) if_circ ();

  assign if_sat.i_flush      = flush;
  assign if_sat.i_call       = call;
  assign if_sat.i_call_addr  = caddr;
  assign if_sat.i_ret        = ret;
  assign if_sat.i_ret_addr   = raddr;
  assign if_sat.i_viol_ack   = ack;
  assign if_sat.i_clr_sticky = clr;
  assign if_circ.i_flush      = flush;
  assign if_circ.i_call       = call;
  assign if_circ.i_call_addr  = caddr;
  assign if_circ.i_ret        = ret;
  assign if_circ.i_ret_addr   = raddr;
  assign if_circ.i_viol_ack   = ack;
  assign if_circ.i_clr_sticky = clr;

  ras_shadow_stack_chk #(.DATA_W(64), .DEPTH(4), .OVF_MODE(0)) u_sat (
    .clk(clk), .rstn(rstn), .bus(if_sat));
  ras_shadow_stack_chk #(.DATA_W(64), .DEPTH(4), .OVF_MODE(1)) u_circ (
    .clk(clk), .rstn(rstn), .bus(if_circ));

  function automatic void sb_push(input int sel, input logic v, input logic [63:0] e,
                                  input logic [63:0] a);
    sb_t t;
    t.sel = sel; t.viol = v; t.e = e; t.a = a;
    sb_q.push_back(t);
  endfunction

  function automatic void sb_both(input logic v, input logic [63:0] e, input logic [63:0] a);
    sb_push(0, v, e, a);
    sb_push(1, v, e, a);
  endfunction

  // One clock: drive at a falling edge, sample at the next falling edge, then
  // drain the scoreboard expectations queued for this cycle's returns.
  task automatic step(input logic c, input logic [63:0] ca, input logic r,
                      input logic [63:0] ra);
    sb_t         ent;
    bit          seen0, seen1;
    logic        v;
    logic [63:0] oe, oa;
    seen0 = 0; seen1 = 0;
    call = c; caddr = ca; ret = r; raddr = ra;
    @(negedge clk);
    call = 0; ret = 0; flush = 0; ack = 0; clr = 0; rstn = 1'b1;
    while (sb_q.size() > 0) begin
      ent = sb_q.pop_front();
      v  = (ent.sel == 0) ? if_sat.o_viol     : if_circ.o_viol;
      oe = (ent.sel == 0) ? if_sat.o_viol_exp : if_circ.o_viol_exp;
      oa = (ent.sel == 0) ? if_sat.o_viol_act : if_circ.o_viol_act;
      if (ent.sel == 0) seen0 = 1; else seen1 = 1;
      tests++;
      if (v !== ent.viol || (ent.viol && (oe !== ent.e || oa !== ent.a))) begin
        failed++;
        $display("FAIL sb_viol dut%0d: viol=%0b exp=%h act=%h, required viol=%0b exp=%h act=%h",
                 ent.sel, v, oe, oa, ent.viol, ent.e, ent.a);
      end
    end
    if (!seen0 && if_sat.o_viol) begin
      tests++; failed++;
      $display("FAIL sb_unexpected_viol dut0: viol=1, required 0");
    end
    if (!seen1 && if_circ.o_viol) begin
      tests++; failed++;
      $display("FAIL sb_unexpected_viol dut1: viol=1, required 0");
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (if_sat.o_empty !== 1'b1 || if_sat.o_count !== 3'd0 || if_sat.o_top !== 64'd0) begin
      failed++;
      $display("FAIL rst_stack_sat: empty=%0b count=%0d top=%h, required 1 0 0",
               if_sat.o_empty, if_sat.o_count, if_sat.o_top);
    end
    tests++;
    if ({if_sat.o_full, if_sat.o_halted, if_sat.o_viol, if_sat.o_ovf, if_sat.o_unf,
         if_sat.o_desync} !== 6'b0 || if_sat.o_viol_exp !== 64'd0 || if_sat.o_viol_act !== 64'd0) begin
      failed++;
      $display("FAIL rst_flags_sat: some flag or violation field nonzero, required all 0");
    end
    tests++;
    if (if_circ.o_empty !== 1'b1 || if_circ.o_halted !== 1'b0 || if_circ.o_count !== 3'd0) begin
      failed++;
      $display("FAIL rst_circ: empty=%0b halted=%0b count=%0d, required 1 0 0",
               if_circ.o_empty, if_circ.o_halted, if_circ.o_count);
    end
  endtask

  task automatic test_push_pop();
    do_reset();
    step(1, 64'h100, 0, 0);
    step(1, 64'h200, 0, 0);
    step(1, 64'h300, 0, 0);
    sb_both(0, 0, 0); step(0, 0, 1, 64'h300);
    sb_both(0, 0, 0); step(0, 0, 1, 64'h200);
    tests++;
    if (if_sat.o_top !== 64'h100 || if_sat.o_count !== 3'd1) begin
      failed++;
      $display("FAIL pp_sat: top=%h count=%0d, required 100 1", if_sat.o_top, if_sat.o_count);
    end
    tests++;
    if (if_circ.o_top !== 64'h100 || if_circ.o_count !== 3'd1) begin
      failed++;
      $display("FAIL pp_circ: top=%h count=%0d, required 100 1", if_circ.o_top, if_circ.o_count);
    end
  endtask

  task automatic test_mismatch();
    do_reset();
    step(1, 64'h100, 0, 0);
    sb_both(1, 64'h100, 64'h104);
    step(0, 0, 1, 64'h104);
    tests++;
    if (if_sat.o_halted !== 1'b1 || if_sat.o_count !== 3'd0) begin
      failed++;
      $display("FAIL mis_halt: halted=%0b count=%0d, required 1 0", if_sat.o_halted, if_sat.o_count);
    end
    step(0, 0, 0, 0);
    tests++;
    if (if_sat.o_viol !== 1'b0 || if_sat.o_viol_exp !== 64'h100 || if_sat.o_viol_act !== 64'h104) begin
      failed++;
      $display("FAIL mis_pulse: viol=%0b exp=%h act=%h, required 0 100 104",
               if_sat.o_viol, if_sat.o_viol_exp, if_sat.o_viol_act);
    end
    step(1, 64'h500, 0, 0);
    tests++;
    if (if_sat.o_count !== 3'd0 || if_sat.o_halted !== 1'b1) begin
      failed++;
      $display("FAIL mis_halt_call: count=%0d halted=%0b, required 0 1", if_sat.o_count, if_sat.o_halted);
    end
    ack = 1'b1;
    step(0, 0, 0, 0);
    tests++;
    if (if_sat.o_halted !== 1'b0) begin
      failed++;
      $display("FAIL mis_ack: halted=%0b, required 0", if_sat.o_halted);
    end
    step(1, 64'h600, 0, 0);
    tests++;
    if (if_sat.o_count !== 3'd1 || if_sat.o_top !== 64'h600) begin
      failed++;
      $display("FAIL mis_after_ack: count=%0d top=%h, required 1 600", if_sat.o_count, if_sat.o_top);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 6; i++) step(1, 64'(i), 0, 0);
    tests++;
    if (if_sat.o_full !== 1'b1 || if_sat.o_ovf !== 1'b1 || if_sat.o_top !== 64'd4 ||
        if_sat.o_count !== 3'd4) begin
      failed++;
      $display("FAIL ovf_sat: full=%0b ovf=%0b top=%h count=%0d, required 1 1 4 4",
               if_sat.o_full, if_sat.o_ovf, if_sat.o_top, if_sat.o_count);
    end
    tests++;
    if (if_circ.o_ovf !== 1'b1 || if_circ.o_top !== 64'd6 || if_circ.o_count !== 3'd4) begin
      failed++;
      $display("FAIL ovf_circ: ovf=%0b top=%h count=%0d, required 1 6 4",
               if_circ.o_ovf, if_circ.o_top, if_circ.o_count);
    end
    // Saturating: 6,5 belong to dropped calls; circular: 6..3 stored, 2,1 underflow.
    for (int i = 6; i >= 1; i--) begin
      sb_both(0, 0, 0);
      step(0, 0, 1, 64'(i));
      if (i == 3) begin
        tests++;
        if (if_circ.o_unf !== 1'b0 || if_circ.o_count !== 3'd0 || if_sat.o_count !== 3'd2) begin
          failed++;
          $display("FAIL ovf_mid: circ_unf=%0b circ_count=%0d sat_count=%0d, required 0 0 2",
                   if_circ.o_unf, if_circ.o_count, if_sat.o_count);
        end
      end
      if (i == 2) begin
        tests++;
        if (if_circ.o_unf !== 1'b1) begin
          failed++;
          $display("FAIL ovf_circ_unf: unf=%0b, required 1", if_circ.o_unf);
        end
      end
    end
    tests++;
    if (if_sat.o_unf !== 1'b0 || if_sat.o_empty !== 1'b1) begin
      failed++;
      $display("FAIL ovf_sat_end: unf=%0b empty=%0b, required 0 1", if_sat.o_unf, if_sat.o_empty);
    end
    clr = 1'b1;
    step(0, 0, 0, 0);
    tests++;
    if (if_sat.o_ovf !== 1'b0 || if_circ.o_ovf !== 1'b0 || if_circ.o_unf !== 1'b0) begin
      failed++;
      $display("FAIL ovf_clr: sat_ovf=%0b circ_ovf=%0b circ_unf=%0b, required 0 0 0",
               if_sat.o_ovf, if_circ.o_ovf, if_circ.o_unf);
    end
  endtask

  task automatic test_desync();
    do_reset();
    for (int i = 1; i <= 8; i++) step(1, 64'(i), 0, 0);
    tests++;
    if (if_sat.o_desync !== 1'b1 || if_circ.o_desync !== 1'b0) begin
      failed++;
      $display("FAIL ds_set: sat=%0b circ=%0b, required 1 0", if_sat.o_desync, if_circ.o_desync);
    end
    // Desynced stack pops without compare; the circular one holds 5..8 and must flag it.
    sb_push(0, 0, 0, 0);
    sb_push(1, 1, 64'd8, 64'h99);
    step(0, 0, 1, 64'h99);
    tests++;
    if (if_sat.o_count !== 3'd3 || if_sat.o_halted !== 1'b0) begin
      failed++;
      $display("FAIL ds_pop: count=%0d halted=%0b, required 3 0", if_sat.o_count, if_sat.o_halted);
    end
    flush = 1'b1;
    step(0, 0, 0, 0);
    tests++;
    if (if_sat.o_desync !== 1'b0 || if_sat.o_count !== 3'd0 || if_sat.o_ovf !== 1'b1) begin
      failed++;
      $display("FAIL ds_flush: desync=%0b count=%0d ovf=%0b, required 0 0 1",
               if_sat.o_desync, if_sat.o_count, if_sat.o_ovf);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1, 64'hA, 0, 0);
    sb_both(0, 0, 0);
    step(1, 64'hB, 1, 64'hA);
    tests++;
    if (if_sat.o_top !== 64'hB || if_sat.o_count !== 3'd1 || if_circ.o_top !== 64'hB) begin
      failed++;
      $display("FAIL b2b_one: top=%h count=%0d circ_top=%h, required b 1 b",
               if_sat.o_top, if_sat.o_count, if_circ.o_top);
    end
    step(1, 64'h11, 0, 0);
    step(1, 64'h12, 0, 0);
    step(1, 64'h13, 0, 0);
    sb_both(0, 0, 0);
    step(1, 64'h14, 1, 64'h13);
    tests++;
    if (if_sat.o_top !== 64'h14 || if_sat.o_count !== 3'd4 || if_sat.o_ovf !== 1'b0) begin
      failed++;
      $display("FAIL b2b_full_sat: top=%h count=%0d ovf=%0b, required 14 4 0",
               if_sat.o_top, if_sat.o_count, if_sat.o_ovf);
    end
    tests++;
    if (if_circ.o_top !== 64'h14 || if_circ.o_count !== 3'd4 || if_circ.o_ovf !== 1'b0) begin
      failed++;
      $display("FAIL b2b_full_circ: top=%h count=%0d ovf=%0b, required 14 4 0",
               if_circ.o_top, if_circ.o_count, if_circ.o_ovf);
    end
    sb_both(0, 0, 0); step(0, 0, 1, 64'h14);
    sb_both(0, 0, 0); step(0, 0, 1, 64'h12);
    flush = 1'b1;
    step(0, 0, 0, 0);
    sb_both(0, 0, 0);
    step(1, 64'h55, 1, 64'h77);
    tests++;
    if (if_sat.o_unf !== 1'b1 || if_sat.o_top !== 64'h55 || if_sat.o_count !== 3'd1) begin
      failed++;
      $display("FAIL b2b_empty: unf=%0b top=%h count=%0d, required 1 55 1",
               if_sat.o_unf, if_sat.o_top, if_sat.o_count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 1; i <= 4; i++) step(1, 64'(i), 0, 0);
    sb_both(1, 64'd4, 64'd9);
    step(0, 0, 1, 64'd9);
    tests++;
    if (if_sat.o_halted !== 1'b1 || if_sat.o_count !== 3'd3) begin
      failed++;
      $display("FAIL rm_pre: halted=%0b count=%0d, required 1 3", if_sat.o_halted, if_sat.o_count);
    end
    rstn = 1'b0;
    step(0, 0, 0, 0);
    tests++;
    if (if_sat.o_empty !== 1'b1 || if_sat.o_halted !== 1'b0 || if_sat.o_count !== 3'd0 ||
        {if_sat.o_viol, if_sat.o_ovf, if_sat.o_unf, if_sat.o_desync} !== 4'b0 ||
        if_sat.o_viol_exp !== 64'd0 || if_sat.o_viol_act !== 64'd0) begin
      failed++;
      $display("FAIL rm_post: empty=%0b halted=%0b count=%0d exp=%h, required 1 0 0 0",
               if_sat.o_empty, if_sat.o_halted, if_sat.o_count, if_sat.o_viol_exp);
    end
    step(1, 64'h20, 0, 0);
    flush = 1'b1;
    step(1, 64'h30, 0, 0);
    tests++;
    if (if_sat.o_empty !== 1'b1 || if_sat.o_count !== 3'd0 || if_sat.o_top !== 64'd0) begin
      failed++;
      $display("FAIL rm_flush_call: empty=%0b count=%0d top=%h, required 1 0 0",
               if_sat.o_empty, if_sat.o_count, if_sat.o_top);
    end
  endtask

  initial begin
    rstn = 1'b0; flush = 0; call = 0; ret = 0; ack = 0; clr = 0; caddr = '0; raddr = '0;
    @(negedge clk);
    test_reset();
    test_push_pop();
    test_mismatch();
    test_overflow();
    test_desync();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at 200000, required completion");
    $fatal(1, "timeout");
  end

endmodule
